// File: rtl/led_pwm_driver.sv
// Multi-channel LED driver: shared prescaler and PWM counter, with per-channel OFF/ON/BLINK/BREATHE modes.
// A single shadow config slot is committed to its channel only on the last cycle of a PWM period.
module led_pwm_driver #(
    parameter int unsigned NUM_CH       = 8,
    parameter int unsigned DUTY_W       = 8,
    parameter int unsigned PRESCALE_DIV = 50000,
    parameter int unsigned BLINK_W      = 8,
    parameter bit          HEARTBEAT    = 1'b1
) (
    input  logic               aclk,
    input  logic               arstn,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [7:0]         cfg_chan,
    input  logic [1:0]         cfg_mode,
    input  logic [DUTY_W-1:0]  cfg_duty,
    input  logic [BLINK_W-1:0] cfg_half,
    output logic               tick,
    output logic [NUM_CH-1:0]  led
);

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_ON      = 2'd1,
        MODE_BLINK   = 2'd2,
        MODE_BREATHE = 2'd3
    } mode_t;

    typedef enum logic {
        SLOT_FREE    = 1'b0,
        SLOT_PENDING = 1'b1
    } slot_t;

    localparam int unsigned      PRE_W    = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE_DIV - 1);

    logic [PRE_W-1:0]   r_pre;
    logic [PRE_W-1:0]   w_pre_next;
    logic               r_tick;
    logic [DUTY_W-1:0]  r_pwm;
    logic               w_pwm_last;

    slot_t              r_slot;
    slot_t              w_slot_next;
    logic               w_xfer;
    logic               w_apply;
    logic [7:0]         r_sh_chan;
    mode_t              r_sh_mode;
    logic [DUTY_W-1:0]  r_sh_duty;
    logic [BLINK_W-1:0] r_sh_half;

    logic [NUM_CH-1:0]  w_on;
    logic [NUM_CH-1:0]  r_led;

    // tick is registered off the next count so it is high while the count sits at PRESCALE_DIV-1
    always_comb begin
        w_pre_next = (r_pre == PRE_LAST) ? '0 : r_pre + 1'b1;
    end

    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            r_pre  <= '0;
            r_tick <= 1'b0;
            r_pwm  <= '0;
        end else begin
            r_pre  <= w_pre_next;
            r_tick <= (w_pre_next == PRE_LAST);
            r_pwm  <= r_pwm + 1'b1;
        end
    end

    assign w_pwm_last = &r_pwm;

    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            r_slot <= SLOT_FREE;
        end else begin
            r_slot <= w_slot_next;
        end
    end

    always_comb begin
        w_slot_next = r_slot;
        w_xfer      = 1'b0;
        w_apply     = 1'b0;
        case (r_slot)
            SLOT_FREE: begin
                if (cfg_valid) begin
                    w_xfer      = 1'b1;
                    w_slot_next = SLOT_PENDING;
                end
            end
            SLOT_PENDING: begin
                if (w_pwm_last) begin
                    w_apply     = 1'b1;
                    w_slot_next = SLOT_FREE;
                end
            end
            default: w_slot_next = SLOT_FREE;
        endcase
    end

    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            r_sh_chan <= '0;
            r_sh_mode <= MODE_OFF;
            r_sh_duty <= '0;
            r_sh_half <= '0;
        end else if (w_xfer) begin
            r_sh_chan <= cfg_chan;
            r_sh_mode <= mode_t'(cfg_mode);
            r_sh_duty <= cfg_duty;
            r_sh_half <= cfg_half;
        end
    end

    assign cfg_ready = (r_slot == SLOT_FREE);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        localparam bit                 HB       = HEARTBEAT && (g == 0);
        localparam mode_t              RST_MODE = HB ? MODE_BLINK : MODE_OFF;
        localparam logic [DUTY_W-1:0]  RST_DUTY = HB ? {DUTY_W{1'b1}} : {DUTY_W{1'b0}};
        localparam logic [BLINK_W-1:0] RST_HALF = HB ? (BLINK_W'(1) << (BLINK_W - 1)) : {BLINK_W{1'b0}};

        mode_t              r_mode;
        logic [DUTY_W-1:0]  r_duty;
        logic [BLINK_W-1:0] r_half;
        logic [BLINK_W-1:0] r_cnt;
        logic               r_phase;
        logic [DUTY_W-1:0]  r_level;
        logic               r_down;
        logic [BLINK_W-1:0] w_half_m1;
        logic               w_step;
        logic               w_apply_ch;
        logic [DUTY_W-1:0]  w_eff;

        assign w_apply_ch = w_apply && (32'(r_sh_chan) == g);
        assign w_half_m1  = (r_half == '0) ? '0 : r_half - 1'b1;
        assign w_step     = (r_cnt >= w_half_m1);

        always_comb begin
            w_eff = '0;
            case (r_mode)
                MODE_OFF:     w_eff = '0;
                MODE_ON:      w_eff = r_duty;
                MODE_BLINK:   w_eff = r_phase ? '0 : r_duty;
                MODE_BREATHE: w_eff = r_level;
                default:      w_eff = '0;
            endcase
        end

        assign w_on[g] = (&w_eff) | (r_pwm < w_eff);

        // An apply takes priority over a coincident tick for this channel only
        always_ff @(posedge aclk or negedge arstn) begin
            if (!arstn) begin
                r_mode  <= RST_MODE;
                r_duty  <= RST_DUTY;
                r_half  <= RST_HALF;
                r_cnt   <= '0;
                r_phase <= 1'b0;
                r_level <= '0;
                r_down  <= 1'b0;
            end else if (w_apply_ch) begin
                r_mode  <= r_sh_mode;
                r_duty  <= r_sh_duty;
                r_half  <= r_sh_half;
                r_cnt   <= '0;
                r_phase <= 1'b0;
                r_level <= '0;
                r_down  <= 1'b0;
            end else if (r_tick && (r_mode == MODE_BLINK || r_mode == MODE_BREATHE)) begin
                if (w_step) begin
                    r_cnt <= '0;
                    if (r_mode == MODE_BLINK) begin
                        r_phase <= ~r_phase;
                    end else if (r_duty == '0) begin
                        r_level <= '0;
                        r_down  <= 1'b0;
                    end else if (!r_down) begin
                        if (r_level >= r_duty) begin
                            r_level <= r_level - 1'b1;
                            r_down  <= 1'b1;
                        end else begin
                            r_level <= r_level + 1'b1;
                            if (r_level == r_duty - 1'b1) begin
                                r_down <= 1'b1;
                            end
                        end
                    end else begin
                        if (r_level != '0) begin
                            r_level <= r_level - 1'b1;
                        end
                        if (r_level <= DUTY_W'(1)) begin
                            r_down <= 1'b0;
                        end
                    end
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            r_led <= '0;
        end else begin
            r_led <= w_on;
        end
    end

    assign tick = r_tick;
    assign led  = r_led;

endmodule

// File: tb/tb_led_pwm_driver.sv
// Directed bench for led_pwm_driver: per-cycle expectations come from a closed-form model of each mode
// and flow through a scoreboard queue; the asynchronous reset is checked between clock edges.
module tb_led_pwm_driver;

    localparam int NCH = 4;

    logic       aclk      = 1'b0;
    logic       arstn     = 1'b0;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [7:0] cfg_chan  = '0;
    logic [1:0] cfg_mode  = '0;
    logic [3:0] cfg_duty  = '0;
    logic [3:0] cfg_half  = '0;
    logic       tick;
    logic [3:0] led;

    led_pwm_driver #(
        .NUM_CH       (4),
        .DUTY_W       (4),
        .PRESCALE_DIV (4),
        .BLINK_W      (4),
        .HEARTBEAT    (1'b0)
    ) dut (
        .aclk      (aclk),
        .arstn     (arstn),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_chan  (cfg_chan),
        .cfg_mode  (cfg_mode),
        .cfg_duty  (cfg_duty),
        .cfg_half  (cfg_half),
        .tick      (tick),
        .led       (led)
    );

    always #5 aclk = ~aclk;

    int checks   = 0;
    int failures = 0;
    int k        = 0;   // rising edges since reset release

    int m_mode [NCH];
    int m_duty [NCH];
    int m_half [NCH];
    int m_j0   [NCH];   // edge at which the channel's settings were applied

    bit p_valid = 1'b0;
    int p_chan, p_mode, p_duty, p_half, p_apply;

    typedef struct packed {
        logic [3:0] led;
        logic       tick;
        logic       ready;
    } exp_t;

    exp_t sb[$];

    function automatic int ch_eff(input int c, input int kk);
        int s, n, r, d;
        d = m_duty[c];
        s = 4 * ((m_half[c] == 0) ? 1 : m_half[c]);
        n = (kk - 1 - m_j0[c]) / s;
        case (m_mode[c])
            1: return d;
            2: return (n % 2 == 0) ? d : 0;
            3: begin
                if (d == 0) return 0;
                r = n % (2 * d);
                return (r <= d) ? r : 2 * d - r;
            end
            default: return 0;
        endcase
    endfunction

    // led value visible after edge kk: compare used pwm_cnt = (kk-1) mod 16
    function automatic logic [3:0] exp_led(input int kk);
        logic [3:0] v;
        int e, pw;
        v  = '0;
        pw = (kk - 1) % 16;
        for (int c = 0; c < NCH; c++) begin
            e    = ch_eff(c, kk);
            v[c] = (e == 15) || (pw < e);
        end
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, k, obs, expv);
        end
    endtask

    task automatic step(input bit xfer);
        exp_t e;
        e.led = exp_led(k + 1);
        if (p_valid && (k + 1) == p_apply) begin
            if (p_chan < NCH) begin
                m_mode[p_chan] = p_mode;
                m_duty[p_chan] = p_duty;
                m_half[p_chan] = p_half;
                m_j0[p_chan]   = k + 1;
            end
            p_valid = 1'b0;
        end
        if (xfer) begin
            p_valid = 1'b1;
            p_chan  = int'(cfg_chan);
            p_mode  = int'(cfg_mode);
            p_duty  = int'(cfg_duty);
            p_half  = int'(cfg_half);
            p_apply = ((k + 1) / 16 + 1) * 16;
        end
        e.tick  = ((k + 1) % 4 == 3);
        e.ready = !p_valid;
        sb.push_back(e);
        @(posedge aclk);
        k++;
        @(negedge aclk);
        e = sb.pop_front();
        chk("led",       32'(led),       32'(e.led));
        chk("tick",      32'(tick),      32'(e.tick));
        chk("cfg_ready", 32'(cfg_ready), 32'(e.ready));
    endtask

    task automatic run(input int n);
        repeat (n) step(1'b0);
    endtask

    // valid is raised at once and held; the transfer lands on the first edge with the slot free
    task automatic write_cfg(input int ch, input int md, input int dt, input int hf);
        int guard;
        guard     = 0;
        cfg_valid = 1'b1;
        cfg_chan  = 8'(ch);
        cfg_mode  = 2'(md);
        cfg_duty  = 4'(dt);
        cfg_half  = 4'(hf);
        while (p_valid && guard < 64) begin
            step(1'b0);
            guard++;
        end
        step(1'b1);
        cfg_valid = 1'b0;
        cfg_chan  = 8'($urandom);
        cfg_mode  = 2'($urandom);
        cfg_duty  = 4'($urandom);
        cfg_half  = 4'($urandom);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog k=%0d", k);
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        #12;
        chk("rst_led",   32'(led),       32'h0);
        chk("rst_tick",  32'(tick),      32'h0);
        chk("rst_ready", 32'(cfg_ready), 32'h1);
        @(negedge aclk);
        arstn = 1'b1;
        k     = 0;

        run(200);

        write_cfg(1, 1, 4, 0);
        run(48);
        write_cfg(1, 1, 15, 0);
        run(40);
        write_cfg(1, 1, 0, 0);
        run(40);

        write_cfg(2, 2, 15, 2);
        run(64);
        write_cfg(2, 2, 15, 0);
        run(40);

        write_cfg(3, 3, 3, 4);
        run(160);
        write_cfg(3, 3, 3, 1);
        run(64);

        write_cfg(9, 1, 15, 0);
        write_cfg(0, 0, 0, 0);
        run(40);

        // leave a write pending, then reset between edges while an LED is lit
        guard = 0;
        while (k % 16 != 0 && guard < 16) begin
            step(1'b0);
            guard++;
        end
        write_cfg(1, 1, 15, 0);
        guard = 0;
        while (exp_led(k) == 4'h0 && guard < 12) begin
            step(1'b0);
            guard++;
        end
        chk("pre_rst_ready", 32'(cfg_ready), 32'h0);
        #2;
        arstn = 1'b0;
        #1;
        chk("async_rst_led",   32'(led),       32'h0);
        chk("async_rst_ready", 32'(cfg_ready), 32'h1);
        chk("async_rst_tick",  32'(tick),      32'h0);
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("held_rst_led", 32'(led), 32'h0);
        for (int c = 0; c < NCH; c++) begin
            m_mode[c] = 0;
            m_duty[c] = 0;
            m_half[c] = 0;
            m_j0[c]   = 0;
        end
        p_valid = 1'b0;
        arstn   = 1'b1;
        k       = 0;
        run(64);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
